// File: rtl/float_div_seq.sv
// Iterative radix-2 restoring binary32 divider (left_operand / right_operand).
// Latency: specials 1 cycle (done registered at the accepting edge); normal path
// done registered 27 edges after the accepting edge. Backpressure: start is only
// sampled in IDLE; requests while busy are ignored, so callers stall on busy.
// Ports: clk, rst (sync active-high), start, left_operand, right_operand in;
//        busy, done (1-cycle pulse), result (held until the next done) out.
// Build option: define FDIV_ROUND_NEAREST_EN for round-to-nearest-even,
// otherwise the quotient is truncated (round toward zero).
module float_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] left_operand,
  input  logic [31:0] right_operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DIVIDE    = 2'd1,
    S_NORMALIZE = 2'd2
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t             state_q, state_d;
  logic [23:0]        mb_q, mb_d;        // divisor significand with hidden bit
  logic [24:0]        rem_q, rem_d;      // partial remainder, always < 2*mb
  logic [25:0]        quo_q, quo_d;      // quotient bits, quo[25] has weight 2^0
  logic [4:0]         cnt_q, cnt_d;
  logic signed [9:0]  exp_q, exp_d;      // biased exponent, may leave [1,254]
  logic               sign_q, sign_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;

  // Operand decode; exponent zero is flushed to zero (no subnormals).
  logic [7:0]  e_l, e_r;
  logic [22:0] f_l, f_r;
  logic        l_zero, r_zero, l_inf, r_inf, l_nan, r_nan, sign_w;

  assign e_l    = left_operand[30:23];
  assign e_r    = right_operand[30:23];
  assign f_l    = left_operand[22:0];
  assign f_r    = right_operand[22:0];
  assign l_zero = (e_l == 8'd0);
  assign r_zero = (e_r == 8'd0);
  assign l_inf  = (e_l == 8'hFF) && (f_l == 23'd0);
  assign r_inf  = (e_r == 8'hFF) && (f_r == 23'd0);
  assign l_nan  = (e_l == 8'hFF) && (f_l != 23'd0);
  assign r_nan  = (e_r == 8'hFF) && (f_r != 23'd0);
  assign sign_w = left_operand[31] ^ right_operand[31];

  // One restoring step. Because rem < 2*mb holds throughout, rem-mb fits in
  // 24 bits and both shifted forms fit back into 25 bits.
  logic        step_ge;
  logic [24:0] step_diff;

  assign step_ge   = (rem_q >= {1'b0, mb_q});
  assign step_diff = rem_q - {1'b0, mb_q};

  // Normalisation and rounding of the finished quotient.
  logic [22:0]       n_frac;
  logic signed [9:0] n_exp;
  logic              n_inc;
  logic [23:0]       n_sum;
  logic signed [9:0] n_exp_r;
`ifdef FDIV_ROUND_NEAREST_EN
  logic              n_guard, n_sticky;
`endif

  always_comb begin
    n_frac = 23'd0;
    n_exp  = exp_q;
    n_inc  = 1'b0;
`ifdef FDIV_ROUND_NEAREST_EN
    n_guard  = 1'b0;
    n_sticky = 1'b0;
`endif
    if (quo_q[25]) begin
      n_frac = quo_q[24:2];
      n_exp  = exp_q;
`ifdef FDIV_ROUND_NEAREST_EN
      n_guard  = quo_q[1];
      n_sticky = quo_q[0] | (|rem_q);
`endif
    end else begin
      // Quotient in [0.5,1): one extra bit of precision, exponent drops by one.
      n_frac = quo_q[23:1];
      n_exp  = exp_q - 10'sd1;
`ifdef FDIV_ROUND_NEAREST_EN
      n_guard  = quo_q[0];
      n_sticky = |rem_q;
`endif
    end
`ifdef FDIV_ROUND_NEAREST_EN
    n_inc = n_guard & (n_sticky | n_frac[0]);
`endif
    // A carry out of the fraction leaves n_sum[22:0] zero and bumps the exponent.
    n_sum   = {1'b0, n_frac} + {23'd0, n_inc};
    n_exp_r = n_exp + $signed({9'd0, n_sum[23]});
  end

  always_comb begin
    state_d  = state_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (l_nan || r_nan || (l_zero && r_zero) || (l_inf && r_inf)) begin
            result_d = QNAN;
            done_d   = 1'b1;
          end else if (l_inf || r_zero) begin
            result_d = {sign_w, 8'hFF, 23'd0};
            done_d   = 1'b1;
          end else if (l_zero || r_inf) begin
            result_d = {sign_w, 8'h00, 23'd0};
            done_d   = 1'b1;
          end else begin
            mb_d    = {1'b1, f_r};
            rem_d   = {2'b01, f_l};
            quo_d   = 26'd0;
            cnt_d   = 5'd0;
            exp_d   = $signed({2'b00, e_l}) - $signed({2'b00, e_r}) + 10'sd127;
            sign_d  = sign_w;
            state_d = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        quo_d = {quo_q[24:0], step_ge};
        rem_d = step_ge ? {step_diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) begin
          state_d = S_NORMALIZE;
        end
      end

      S_NORMALIZE: begin
        if (n_exp_r >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
        end else if (n_exp_r <= 10'sd0) begin
          result_d = {sign_q, 8'h00, 23'd0};
        end else begin
          result_d = {sign_q, n_exp_r[7:0], n_sum[22:0]};
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mb_q     <= 24'd0;
      rem_q    <= 25'd0;
      quo_q    <= 26'd0;
      cnt_q    <= 5'd0;
      exp_q    <= 10'sd0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Busy is a pure decode of the state register, so it rises at the accepting
  // edge and falls at the edge that registers done.
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_float_div_seq.sv
module tb_float_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] left_operand;
  logic [31:0] right_operand;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef FDIV_ROUND_NEAREST_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  float_div_seq dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .left_operand  (left_operand),
    .right_operand (right_operand),
    .busy          (busy),
    .done          (done),
    .result        (result)
  );

  always #5 clk = ~clk;

  // Issues one request from the current negedge and waits for done.
  // edges = posedges after the accepting one until done is registered (-1 on timeout).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int edges, output int busy_cyc);
    start         = 1'b1;
    left_operand  = a;
    right_operand = b;
    edges    = -1;
    busy_cyc = 0;
    res      = 32'hxxxxxxxx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start         = 1'b0;
      left_operand  = 32'hDEADBEEF;   // operands must not be re-sampled
      right_operand = 32'h12345678;
      if (busy) busy_cyc++;
      if (done) begin
        edges = k;
        res   = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; left_operand = 32'd0; right_operand = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    rst = 1'b0;
  endtask

  task automatic test_divide();
    logic [31:0] r; int e, b;
    @(negedge clk);
    run_div(32'h40C00000, 32'h40000000, r, e, b);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL six_by_two: got %h expected 40400000", r); end
    checks++; if (e !== 27) begin errors++; $display("FAIL six_by_two_latency: got %0d expected 27", e); end
    checks++; if (b !== 27) begin errors++; $display("FAIL six_by_two_busy: got %0d expected 27", b); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
    checks++; if (result !== 32'h40400000) begin errors++; $display("FAIL result_hold: got %h expected 40400000", result); end
    run_div(32'h3F800000, 32'h40400000, r, e, b);
    checks++; if (r !== THIRD) begin errors++; $display("FAIL one_third: got %h expected %h", r, THIRD); end
    checks++; if (e !== 27) begin errors++; $display("FAIL one_third_latency: got %0d expected 27", e); end
    @(negedge clk);
    // -7.5 / 2.5 = -3.0 exercises sign and a non-trivial divisor significand
    run_div(32'hC0F00000, 32'h40200000, r, e, b);
    checks++; if (r !== 32'hC0400000) begin errors++; $display("FAIL neg_div: got %h expected C0400000", r); end
  endtask

  task automatic test_specials();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vr [6];
    logic [31:0] r; int e, b;
    va[0] = 32'hBF800000; vb[0] = 32'h00000000; vr[0] = 32'hFF800000;  // -1/0
    va[1] = 32'h00000000; vb[1] = 32'h00000000; vr[1] = 32'h7FC00000;  // 0/0
    va[2] = 32'h7FC00000; vb[2] = 32'h3F800000; vr[2] = 32'h7FC00000;  // NaN/1
    va[3] = 32'h7F800000; vb[3] = 32'hFF800000; vr[3] = 32'h7FC00000;  // Inf/-Inf
    va[4] = 32'hFF800000; vb[4] = 32'h40000000; vr[4] = 32'hFF800000;  // -Inf/2
    va[5] = 32'h40000000; vb[5] = 32'hFF800000; vr[5] = 32'h80000000;  // 2/-Inf
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_div(va[i], vb[i], r, e, b);
      checks++; if (r !== vr[i]) begin errors++; $display("FAIL special_%0d: got %h expected %h", i, r, vr[i]); end
      checks++; if (e !== 0) begin errors++; $display("FAIL special_latency_%0d: got %0d expected 0", i, e); end
      checks++; if (b !== 0) begin errors++; $display("FAIL special_busy_%0d: got %0d expected 0", i, b); end
    end
  endtask

  task automatic test_range();
    logic [31:0] r; int e, b;
    @(negedge clk);
    run_div(32'h7F000000, 32'h3F000000, r, e, b);
    checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL overflow: got %h expected 7F800000", r); end
    checks++; if (e !== 27) begin errors++; $display("FAIL overflow_latency: got %0d expected 27", e); end
    @(negedge clk);
    run_div(32'h00800000, 32'h40000000, r, e, b);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL underflow: got %h expected 00000000", r); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] r; int e, nd;
    @(negedge clk);
    start = 1'b1; left_operand = 32'h40C00000; right_operand = 32'h40000000;
    nd = 0; e = -1; r = 32'd0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start         = (k == 4 || k == 9);
      left_operand  = 32'h3F800000;
      right_operand = 32'h40400000;
      if (done) begin
        if (nd == 0) begin e = k; r = result; end
        nd++;
      end
    end
    start = 1'b0;
    checks++; if (nd !== 1) begin errors++; $display("FAIL busy_start_dones: got %0d expected 1", nd); end
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL busy_start_result: got %h expected 40400000", r); end
    checks++; if (e !== 27) begin errors++; $display("FAIL busy_start_latency: got %0d expected 27", e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int e1, e2, b;
    @(negedge clk);
    run_div(32'h3F800000, 32'h40400000, r1, e1, b);
    run_div(32'h40C00000, 32'h40000000, r2, e2, b);  // start lands in the done cycle
    checks++; if (r1 !== THIRD) begin errors++; $display("FAIL b2b_first: got %h expected %h", r1, THIRD); end
    checks++; if (r2 !== 32'h40400000) begin errors++; $display("FAIL b2b_second: got %h expected 40400000", r2); end
    checks++; if (e2 !== 27) begin errors++; $display("FAIL b2b_latency: got %0d expected 27", e2); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; int e, b; bit seen;
    @(negedge clk);
    start = 1'b1; left_operand = 32'h3F800000; right_operand = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h expected 00000000", result); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stray_done: got %b expected 0", seen); end
    run_div(32'h40C00000, 32'h40000000, r, e, b);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL midrst_after: got %h expected 40400000", r); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_specials();
    test_range();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_div_seq.md
Name: float_div_seq

Overview:
- Iterative radix-2 restoring IEEE-754 binary32 divider (left_operand / right_operand).
- Sits beside the combinational/short-pipeline float DSP unit in the execute stage and drives the ALU's float_div_res path.
- Multi-cycle: start/busy/done handshake; the ALU control stalls on busy.

Parameters:
- None. Fixed binary32: 24-bit significands, 26 quotient bits, bias 127.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- left_operand  input  32  dividend, binary32
- right_operand  input  32  divisor, binary32
- busy  output  1  high from the edge accepting start until the edge producing done
- done  output  1  one-cycle pulse; result valid in the same cycle and held until next done
- result  output  32  quotient, binary32

Behaviour:
- Reset (sync, active-high, any state): state=IDLE; busy=0, done=0, result=0x00000000; quotient, remainder and counter cleared. Reset mid-divide aborts with no done.
- Operand decode: exp=0 is treated as zero (subnormals flushed). exp=255 with frac≠0 is NaN. exp=255 with frac=0 is Inf. Sign = sL XOR sR.
- States: IDLE -> DIVIDE -> NORMALIZE -> IDLE.
- IDLE, start=1, special case (edge E0): result and done=1 registered at E0; busy stays 0; stay IDLE. Latency 1.
  - Any NaN, 0/0, or Inf/Inf -> 0x7FC00000.
  - Inf/x or x/0 -> {sign, 0xFF, 0}.
  - 0/x or x/Inf -> {sign, 0x00, 0}.
- IDLE, start=1, normal case (E0):
  - Latch mb={1,fracR}.
  - rem (25b) = {0,1,fracL}; q=0; cnt=0.
  - exp (signed 10b) = eL - eR + 127; sign latched.
  - busy=1; go to DIVIDE.
- DIVIDE: one quotient bit per edge, MSB first.
  - If rem >= mb: q bit=1, rem=(rem-mb)<<1. Else q bit=0, rem=rem<<1.
  - cnt increments; after 26 bits (edges E1..E26) go to NORMALIZE.
- NORMALIZE (E27):
  - If q[25]=1: frac=q[24:2], guard=q[1], sticky=q[0] | (rem≠0).
  - Else: frac=q[23:1], guard=q[0], sticky=(rem≠0), exp=exp-1.
  - Rounding applied (see optional feature). A mantissa carry-out increments exp and zeroes frac.
  - exp >= 255 -> {sign, 0xFF, 0}. exp <= 0 -> {sign, 0x00, 0}.
  - result registered; done=1 for one cycle; busy=0 at the same edge; go to IDLE.
  - Normal-path latency: done high in the cycle after E27 (27 cycles after the accepting edge).
- start while busy: ignored, no effect on the in-flight divide.
- start in the cycle done is high: accepted (state is IDLE), so back-to-back divides are possible.
- Operands need only be valid in the accepting cycle; they are not re-sampled.
- done only ever pulses; it is never held for more than one cycle.

Optional Feature:
- Macro FDIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment frac when guard & (sticky | frac[0]).
- Undefined: truncate (round toward zero); guard and sticky ignored.
- Latency identical in both builds.

Test Plan:
- 6.0/2.0: start with 0x40C00000 / 0x40000000 -> busy for 27 cycles, done pulse, result 0x40400000, same in both builds.
- 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB with FDIV_ROUND_NEAREST_EN, 0x3EAAAAAA without. Latency 27.
- Specials: -1.0/0 (0xBF800000 / 0x00000000) -> 0xFF800000 with done 1 cycle after start, busy never high. 0/0 -> 0x7FC00000. 0x7FC00000/1.0 -> 0x7FC00000.
- Overflow/underflow: 0x7F000000 / 0x3F000000 -> 0x7F800000. 0x00800000 / 0x40000000 -> 0x00000000.
- Handshake: start pulsed again at cycles 5 and 10 of a busy divide -> ignored, single done, correct result. start asserted in the done cycle -> second divide accepted, second done 27 cycles later.
- Reset mid-op: rst=1 at cycle 12 of a divide -> next cycle busy=0, done=0, result=0, no done afterward. A following 6.0/2.0 -> 0x40400000.
